// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: round-robin share of a dual-lane (even/odd byte) ROM
// between instruction fetch (port 0) and data load (port 1).
module rom_port_arbiter #(
  parameter int unsigned SIZE    = 2048,
  parameter logic [15:0] ROMBASE = 16'h4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic        word0,
  input  logic        word1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        valid0,
  output logic        valid1,
  output logic [15:0] data0,
  output logic [15:0] data1,
  output logic        err0,
  output logic        err1,
  output logic [14:0] read_addr_even,
  output logic [14:0] read_addr_odd,
  input  logic [7:0]  read_data_even,
  input  logic [7:0]  read_data_odd
);

  localparam logic [16:0] LO = {1'b0, ROMBASE};
  localparam logic [16:0] HI = 17'(ROMBASE) + 17'(SIZE) - 17'd1;

  logic        last_q, last_d;
  logic [14:0] even_q, even_d;
  logic [14:0] odd_q, odd_d;
  logic        tv_q, tv_d;
  logic        town_q, town_d;
  logic        ta0_q, ta0_d;
  logic        tword_q, tword_d;
  logic        terr_q, terr_d;

  logic        any_gnt;
  logic        sel;
  logic [15:0] a;
  logic        w;
  logic [14:0] wi;
  logic [16:0] a17;
  logic [16:0] a17p1;
  logic        in_rng;

  logic [7:0]  lo_b;
  logic [7:0]  hi_b;
  logic [15:0] rdata;
  logic        rv;

  // last_q names the port granted most recently; the other one wins a tie
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      gnt0 = req0 & (~req1 | last_q);
      gnt1 = req1 & (~req0 | ~last_q);
    end
  end

  assign any_gnt = gnt0 | gnt1;
  assign sel     = gnt1;
  assign a       = sel ? addr1 : addr0;
  assign w       = sel ? word1 : word0;
  assign wi      = a[15:1];
  assign a17     = {1'b0, a};
  assign a17p1   = a17 + 17'd1;

  // 17-bit compare keeps 16'hFFFF+1 from wrapping back into the window
  assign in_rng = (a17 >= LO) && (a17 <= HI)
                  && (!w || (a17p1 <= HI));

  always_comb begin
    last_d  = last_q;
    even_d  = even_q;
    odd_d   = odd_q;
    tv_d    = any_gnt;
    town_d  = sel;
    ta0_d   = a[0];
    tword_d = w;
    terr_d  = ~in_rng;
    if (any_gnt) begin
      last_d = sel;
      odd_d  = wi;
      even_d = a[0] ? wi + 15'd1 : wi;
    end
  end

  assign read_addr_even = even_d;
  assign read_addr_odd  = odd_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= 1'b1;
      even_q  <= '0;
      odd_q   <= '0;
      tv_q    <= 1'b0;
      town_q  <= 1'b0;
      ta0_q   <= 1'b0;
      tword_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      last_q  <= last_d;
      even_q  <= even_d;
      odd_q   <= odd_d;
      tv_q    <= tv_d;
      town_q  <= town_d;
      ta0_q   <= ta0_d;
      tword_q <= tword_d;
      terr_q  <= terr_d;
    end
  end

  // odd start address puts the low byte on the odd lane
  always_comb begin
    lo_b   = ta0_q ? read_data_odd : read_data_even;
    hi_b   = ta0_q ? read_data_even : read_data_odd;
    rdata  = terr_q ? 16'hFFFF
                    : {(tword_q ? hi_b : 8'h00), lo_b};
    rv     = tv_q & ~reset;
    valid0 = rv & ~town_q;
    valid1 = rv & town_q;
    data0  = valid0 ? rdata : 16'h0000;
    data1  = valid1 ? rdata : 16'h0000;
    err0   = valid0 & terr_q;
    err1   = valid1 & terr_q;
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed and randomized checks of rom_port_arbiter
// against a transaction-level model of grants and ROM responses.
module tb_rom_port_arbiter;

  localparam int          SIZE    = 2048;
  localparam logic [15:0] ROMBASE = 16'h4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [15:0] addr0, addr1;
  logic        word0, word1;
  logic        gnt0, gnt1;
  logic        valid0, valid1;
  logic [15:0] data0, data1;
  logic        err0, err1;
  logic [14:0] rae, rao;
  logic [7:0]  rde, rdo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rom_port_arbiter #(.SIZE(SIZE), .ROMBASE(ROMBASE)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .word0(word0), .word1(word1),
    .gnt0(gnt0), .gnt1(gnt1),
    .valid0(valid0), .valid1(valid1),
    .data0(data0), .data1(data1),
    .err0(err0), .err1(err1),
    .read_addr_even(rae), .read_addr_odd(rao),
    .read_data_even(rde), .read_data_odd(rdo)
  );

  // byte contents at absolute address a (rom[i] = romb(ROMBASE+i))
  function automatic logic [7:0] romb(input logic [15:0] a);
    return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'hA5;
  endfunction

  // synchronous ROM stub: one-cycle registered lanes
  always @(posedge clk) begin
    rde <= romb({rae, 1'b0});
    rdo <= romb({rao, 1'b1});
  end

  // expected {err, data} for a read of address a, word w
  function automatic logic [16:0] expect_resp(input logic [15:0] a,
                                              input logic w);
    int ai = int'(a);
    int lo = int'(ROMBASE);
    int hi = int'(ROMBASE) + SIZE - 1;
    bit ok = (ai >= lo) && (ai <= hi) && (!w || (ai + 1 <= hi));
    if (!ok) return {1'b1, 16'hFFFF};
    return {1'b0, (w ? romb(a + 16'd1) : 8'h00), romb(a)};
  endfunction

  function automatic logic [15:0] rnd_addr();
    case ($urandom_range(0, 3))
      0: return 16'($urandom);
      1: return 16'($urandom_range(16'h3FF8, 16'h4008));
      2: return 16'($urandom_range(16'h47F8, 16'h4808));
      default: return 16'($urandom_range(16'h4000, 16'h47FF));
    endcase
  endfunction

  task automatic drive(input logic r,
                       input logic q0, input logic [15:0] a0, input logic w0,
                       input logic q1, input logic [15:0] a1, input logic w1);
    reset = r;
    req0 = q0; addr0 = a0; word0 = w0;
    req1 = q1; addr1 = a1; word1 = w1;
    #1;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 1, 16'h4000, 1, 1, 16'h4002, 0);
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt0 got=%b want=0", gnt0); end
    checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL rst_gnt1 got=%b want=0", gnt1); end
    checks++; if (valid0 !== 1'b0 || valid1 !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b%b want=00", valid0, valid1); end
    checks++; if (data0 !== 16'h0 || data1 !== 16'h0) begin errors++; $display("FAIL rst_data got=%h/%h want=0000/0000", data0, data1); end
    next();
    drive(1, 1, 16'h4000, 1, 1, 16'h4002, 0);
    checks++; if (rae !== 15'h0 || rao !== 15'h0) begin errors++; $display("FAIL rst_lanes got=%h/%h want=0000/0000", rae, rao); end
    checks++; if (err0 !== 1'b0 || err1 !== 1'b0) begin errors++; $display("FAIL rst_err got=%b%b want=00", err0, err1); end
    next();
  endtask

  task automatic test_even_word();
    logic [15:0] exp;
    exp = {romb(16'h4001), romb(16'h4000)};
    drive(0, 1, 16'h4000, 1, 0, 16'h0, 0);
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL even_gnt got=%b%b want=10", gnt0, gnt1); end
    checks++; if (rae !== 15'h2000 || rao !== 15'h2000) begin errors++; $display("FAIL even_lanes got=%h/%h want=2000/2000", rae, rao); end
    next();
    drive(0, 0, 16'h0, 0, 0, 16'h0, 0);
    checks++; if (valid0 !== 1'b1 || err0 !== 1'b0) begin errors++; $display("FAIL even_valid got=%b err=%b want=1 err=0", valid0, err0); end
    checks++; if (data0 !== exp) begin errors++; $display("FAIL even_data got=%h want=%h", data0, exp); end
    checks++; if (valid1 !== 1'b0 || data1 !== 16'h0 || err1 !== 1'b0) begin errors++; $display("FAIL even_port1 got=%b/%h/%b want=0/0000/0", valid1, data1, err1); end
    next();
  endtask

  task automatic test_unaligned();
    logic [15:0] exp;
    exp = {romb(16'h4004), romb(16'h4003)};
    drive(0, 0, 16'h0, 0, 1, 16'h4003, 1);
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL unal_gnt got=%b%b want=01", gnt0, gnt1); end
    checks++; if (rao !== 15'h2001 || rae !== 15'h2002) begin errors++; $display("FAIL unal_lanes got=e%h/o%h want=e2002/o2001", rae, rao); end
    next();
    drive(0, 0, 16'h0, 0, 0, 16'h0, 0);
    checks++; if (valid1 !== 1'b1 || data1 !== exp) begin errors++; $display("FAIL unal_data got=%b/%h want=1/%h", valid1, data1, exp); end
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL unal_valid0 got=%b want=0", valid0); end
    checks++; if (rao !== 15'h2001 || rae !== 15'h2002) begin errors++; $display("FAIL unal_hold got=e%h/o%h want=e2002/o2001", rae, rao); end
    next();
  endtask

  task automatic test_contention();
    logic [16:0] r0, r1;
    r0 = expect_resp(16'h4010, 1'b1);
    r1 = expect_resp(16'h4021, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(0, 1, 16'h4010, 1, 1, 16'h4021, 0);
      else drive(0, 0, 16'h0, 0, 0, 16'h0, 0);
      if (i < 4) begin
        checks++; if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin errors++; $display("FAIL cont_gnt[%0d] got=%b%b want=%b%b", i, gnt0, gnt1, i % 2 == 0, i % 2 == 1); end
      end
      if (i > 0) begin
        checks++; if (valid0 && valid1) begin errors++; $display("FAIL cont_both[%0d] got=11 want=one-hot", i); end
        if ((i - 1) % 2 == 0) begin
          checks++; if (valid0 !== 1'b1 || data0 !== r0[15:0]) begin errors++; $display("FAIL cont_rsp0[%0d] got=%b/%h want=1/%h", i, valid0, data0, r0[15:0]); end
        end else begin
          checks++; if (valid1 !== 1'b1 || data1 !== r1[15:0]) begin errors++; $display("FAIL cont_rsp1[%0d] got=%b/%h want=1/%h", i, valid1, data1, r1[15:0]); end
        end
      end
      next();
    end
  endtask

  task automatic test_range_edges();
    logic [15:0] ra [6] = '{16'h47FF, 16'h47FF, 16'h3FFF, 16'hFFFF, 16'h47FE, 16'h3FFF};
    logic        rw [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        re [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] rd [6];
    logic        p, ov, oe;
    logic [15:0] od;
    rd[0] = {8'h00, romb(16'h47FF)};
    rd[1] = 16'hFFFF;
    rd[2] = 16'hFFFF;
    rd[3] = 16'hFFFF;
    rd[4] = {romb(16'h47FF), romb(16'h47FE)};
    rd[5] = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      p = i[0];
      drive(0, !p, ra[i], rw[i], p, ra[i], rw[i]);
      checks++; if ((p ? gnt1 : gnt0) !== 1'b1) begin errors++; $display("FAIL edge_gnt[%0d] got=%b%b want port %0d", i, gnt0, gnt1, p); end
      if (i == 3) begin
        checks++; if (rao !== 15'h7FFF || rae !== 15'h0000) begin errors++; $display("FAIL edge_wrap got=e%h/o%h want=e0000/o7fff", rae, rao); end
      end
      next();
      drive(0, 0, 16'h0, 0, 0, 16'h0, 0);
      ov = p ? valid1 : valid0;
      oe = p ? err1 : err0;
      od = p ? data1 : data0;
      checks++; if (ov !== 1'b1 || oe !== re[i] || od !== rd[i]) begin errors++; $display("FAIL edge_rsp[%0d] a=%h w=%b got=%b/%b/%h want=1/%b/%h", i, ra[i], rw[i], ov, oe, od, re[i], rd[i]); end
      next();
    end
  endtask

  task automatic test_reset_midflight();
    drive(0, 1, 16'h4000, 1, 0, 16'h0, 0);
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL mid_gnt got=%b want=1", gnt0); end
    next();
    drive(1, 0, 16'h0, 0, 0, 16'h0, 0);
    checks++; if (valid0 !== 1'b0 || data0 !== 16'h0 || err0 !== 1'b0) begin errors++; $display("FAIL mid_suppress got=%b/%h/%b want=0/0000/0", valid0, data0, err0); end
    next();
    drive(0, 1, 16'h4002, 0, 1, 16'h4004, 0);
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL mid_first got=%b%b want=10", gnt0, gnt1); end
    checks++; if (valid0 !== 1'b0 || valid1 !== 1'b0) begin errors++; $display("FAIL mid_idle got=%b%b want=00", valid0, valid1); end
    next();
    drive(0, 0, 16'h0, 0, 0, 16'h0, 0);
    checks++; if (valid0 !== 1'b1 || data0 !== {8'h00, romb(16'h4002)}) begin errors++; $display("FAIL mid_rsp got=%b/%h want=1/%h", valid0, data0, {8'h00, romb(16'h4002)}); end
    next();
  endtask

  task automatic test_random();
    int          win, m_last, p_port;
    bit          p_v, h0, h1, ev0, ev1;
    logic        q0, q1, w0, w1, r, gw;
    logic [15:0] a0, a1, ga;
    logic [16:0] p_resp;
    logic [14:0] m_e, m_o, e_e, e_o, wa;
    drive(1, 0, 16'h0, 0, 0, 16'h0, 0);
    next();
    m_last = 1; p_v = 0; p_port = 0; p_resp = '0;
    m_e = '0; m_o = '0; h0 = 0; h1 = 0;
    q0 = 0; q1 = 0; w0 = 0; w1 = 0; a0 = '0; a1 = '0;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 39) == 0);
      if (!h0) begin q0 = ($urandom_range(0, 9) < 6); a0 = rnd_addr(); w0 = 1'($urandom_range(0, 1)); end
      if (!h1) begin q1 = ($urandom_range(0, 9) < 6); a1 = rnd_addr(); w1 = 1'($urandom_range(0, 1)); end
      drive(r, q0, a0, w0, q1, a1, w1);
      win = -1;
      if (!r) begin
        if (q0 && q1) win = 1 - m_last;
        else if (q0) win = 0;
        else if (q1) win = 1;
      end
      e_e = m_e; e_o = m_o; ga = a0; gw = w0;
      if (win >= 0) begin
        ga = (win == 1) ? a1 : a0;
        gw = (win == 1) ? w1 : w0;
        wa = ga[15:1];
        e_o = wa;
        e_e = ga[0] ? wa + 15'd1 : wa;
      end
      ev0 = !r && p_v && p_port == 0;
      ev1 = !r && p_v && p_port == 1;
      checks++; if (gnt0 !== (win == 0) || gnt1 !== (win == 1)) begin errors++; $display("FAIL rnd_gnt[%0d] got=%b%b want=%b%b", n, gnt0, gnt1, win == 0, win == 1); end
      checks++; if (valid0 !== ev0 || valid1 !== ev1) begin errors++; $display("FAIL rnd_valid[%0d] got=%b%b want=%b%b", n, valid0, valid1, ev0, ev1); end
      checks++; if (data0 !== (ev0 ? p_resp[15:0] : 16'h0) || err0 !== (ev0 && p_resp[16])) begin errors++; $display("FAIL rnd_rsp0[%0d] got=%h/%b want=%h/%b", n, data0, err0, ev0 ? p_resp[15:0] : 16'h0, ev0 && p_resp[16]); end
      checks++; if (data1 !== (ev1 ? p_resp[15:0] : 16'h0) || err1 !== (ev1 && p_resp[16])) begin errors++; $display("FAIL rnd_rsp1[%0d] got=%h/%b want=%h/%b", n, data1, err1, ev1 ? p_resp[15:0] : 16'h0, ev1 && p_resp[16]); end
      checks++; if (rae !== e_e || rao !== e_o) begin errors++; $display("FAIL rnd_lanes[%0d] got=e%h/o%h want=e%h/o%h", n, rae, rao, e_e, e_o); end
      if (r) begin
        m_last = 1; p_v = 0; m_e = '0; m_o = '0;
      end else if (win >= 0) begin
        m_last = win; p_v = 1; p_port = win;
        p_resp = expect_resp(ga, gw);
        m_e = e_e; m_o = e_o;
      end else begin
        p_v = 0;
      end
      h0 = q0 && (win != 0);
      h1 = q1 && (win != 1);
      next();
    end
    drive(0, 0, 16'h0, 0, 0, 16'h0, 0);
    next();
  endtask

  initial begin
    test_reset();
    test_even_word();
    test_unaligned();
    test_contention();
    test_range_edges();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
